neuron_layer_scheduler: RTL

//  Time-multiplexes one fully-parallel N-input neuron datapath (MAC chain + saturation + ReLU,
//  1-cycle registered output) across the M neurons of a layer. Accepts one input vector,

---
 rtl/nn_pkg.sv | 33 +++
 rtl/neuron_layer_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg
// Shared types and width helpers for the neuron layer blocks.
//   sched_state_t : scheduler FSM states
//   act_w / wgt_w : packed widths of one activation / one weight element
// ---------------------------------------------------------------------------
package nn_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      COMPUTE = 3'd2,
      CAPTURE = 3'd3,
      EMIT    = 3'd4
   } sched_state_t;

   // Default fixed-point formats (activation Q12.20, weight Q6.10)
   localparam int QM_DEF = 12;
   localparam int QN_DEF = 20;
   localparam int WM_DEF = 6;
   localparam int WN_DEF = 10;
   localparam int ACT_W  = QM_DEF + QN_DEF;
   localparam int WGT_W  = WM_DEF + WN_DEF;

   function automatic int act_w(input int qm, input int qn);
      return qm + qn;
   endfunction

   function automatic int wgt_w(input int wm, input int wn);
      return wm + wn;
   endfunction

endpackage

// File: rtl/neuron_layer_scheduler.sv
// ---------------------------------------------------------------------------
// neuron_layer_scheduler
// Time-multiplexes one external N-input neuron datapath across the M neurons
// of a layer. One input vector is latched, then for each neuron the weights
// and bias are read from a synchronous memory, presented to the datapath for
// one cycle, and the registered datapath result is streamed out.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   clr           synchronous abort back to IDLE
//   in_valid/in_ready/in_vec        input vector handshake (accepted in IDLE)
//   mem_en/mem_addr/mem_w/mem_b     weight memory, read data 1 cycle later
//   dp_in/dp_weights/dp_bias/dp_out external datapath connection
//   out_valid/out_ready/out_data/out_idx/out_last  result stream
//
// Per neuron: FETCH -> COMPUTE -> CAPTURE -> EMIT, 4 cycles with out_ready
// high. Results are passed through bit-exact; no arithmetic happens here.
// ---------------------------------------------------------------------------
module neuron_layer_scheduler
   import nn_pkg::*;
#(
   parameter int N  = 2,
   parameter int M  = 4,
   parameter int QM = 12,
   parameter int QN = 20,
   parameter int WM = 6,
   parameter int WN = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N*act_w(QM,QN)-1:0]     in_vec,
   output logic                          mem_en,
   output logic [((M>1)?$clog2(M):1)-1:0] mem_addr,
   input  logic [N*wgt_w(WM,WN)-1:0]     mem_w,
   input  logic [act_w(QM,QN)-1:0]       mem_b,
   output logic [N*act_w(QM,QN)-1:0]     dp_in,
   output logic [N*wgt_w(WM,WN)-1:0]     dp_weights,
   output logic [act_w(QM,QN)-1:0]       dp_bias,
   input  logic [act_w(QM,QN)-1:0]       dp_out,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [act_w(QM,QN)-1:0]       out_data,
   output logic [((M>1)?$clog2(M):1)-1:0] out_idx,
   output logic                          out_last
);

   localparam int AW  = (M > 1) ? $clog2(M) : 1;
   localparam int AWD = act_w(QM, QN);
   localparam int WWD = wgt_w(WM, WN);
   localparam logic [AW-1:0] LAST_IDX = AW'(M - 1);

   sched_state_t         state_reg, state_next;
   logic [AW-1:0]        idx_reg, idx_next;
   logic [N*AWD-1:0]     in_reg, in_next;
   logic [AWD-1:0]       out_data_reg, out_data_next;
   logic [AW-1:0]        out_idx_reg, out_idx_next;
   logic                 out_last_reg, out_last_next;
   logic                 in_ready_reg, in_ready_next;
   logic                 mem_en_reg, mem_en_next;
   logic                 out_valid_reg, out_valid_next;

   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      in_next       = in_reg;
      out_data_next = out_data_reg;
      out_idx_next  = out_idx_reg;
      out_last_next = out_last_reg;

      unique case (state_reg)
         IDLE: begin
            // in_ready is high exactly in IDLE, so in_valid alone is the handshake
            if (in_valid) begin
               in_next    = in_vec;
               idx_next   = '0;
               state_next = FETCH;
            end
         end
         FETCH: begin
            state_next = COMPUTE;
         end
         COMPUTE: begin
            state_next = CAPTURE;
         end
         CAPTURE: begin
            out_data_next = dp_out;
            out_idx_next  = idx_reg;
            out_last_next = (idx_reg == LAST_IDX);
            state_next    = EMIT;
         end
         EMIT: begin
            if (out_ready) begin
               if (idx_reg == LAST_IDX) begin
                  state_next = IDLE;
               end else begin
                  idx_next   = idx_reg + AW'(1);
                  state_next = FETCH;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Abort wins over everything, including a same-cycle EMIT handshake
      if (clr) begin
         state_next    = IDLE;
         idx_next      = '0;
         out_last_next = 1'b0;
      end

      // Handshake strobes are registered: they decode the next state
      in_ready_next  = (state_next == IDLE);
      mem_en_next    = (state_next == FETCH);
      out_valid_next = (state_next == EMIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         in_reg        <= '0;
         out_data_reg  <= '0;
         out_idx_reg   <= '0;
         out_last_reg  <= 1'b0;
         in_ready_reg  <= 1'b1;
         mem_en_reg    <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         in_reg        <= in_next;
         out_data_reg  <= out_data_next;
         out_idx_reg   <= out_idx_next;
         out_last_reg  <= out_last_next;
         in_ready_reg  <= in_ready_next;
         mem_en_reg    <= mem_en_next;
         out_valid_reg <= out_valid_next;
      end
   end

   assign in_ready   = in_ready_reg;
   assign mem_en     = mem_en_reg;
   assign mem_addr   = idx_reg;
   assign dp_in      = in_reg;
   // Memory read data is only meaningful in the cycle after FETCH
   assign dp_weights = (state_reg == COMPUTE) ? mem_w : {(N*WWD){1'b0}};
   assign dp_bias    = (state_reg == COMPUTE) ? mem_b : {AWD{1'b0}};
   assign out_valid  = out_valid_reg;
   assign out_data   = out_data_reg;
   assign out_idx    = out_idx_reg;
   assign out_last   = out_last_reg;

endmodule
